// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream, framed into PKT_LEN-beat packets.
// A 2-entry skid buffer absorbs the read latency so the stream can run at 1 beat/cycle.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic       pop;
  logic [1:0] credit;

  // Credit covers both buffered words and the word still in flight from the FIFO.
  assign credit     = occ_q + {1'b0, rd_pend_q};
  assign pop        = m_valid & m_ready;
  assign fifo_rd_en = !fifo_empty & ((credit < 2'd2) | ((credit == 2'd2) & pop));

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid & (beat_cnt_q == LAST_BEAT);
  assign pkt_cnt = pkt_cnt_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({rd_pend_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_dout;
        else               tail_d = fifo_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous capture and pop: occupancy holds, arrival goes behind any remaining word.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = fifo_dout;
        end else begin
          head_d = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 8'd0 : beat_cnt_q + 8'd1;
      if (m_last) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      rd_pend_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_cnt_q <= 8'd0;
      pkt_cnt_q  <= '0;
    end else begin
      occ_q      <= occ_d;
      rd_pend_q  <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule
